// File: rtl/dpr_arb_pkg.sv
// rtl/dpr_arb_pkg.sv - Grant encoding shared by the RAM port-2 arbiter and its bench-facing users
package dpr_arb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_LD   = 2'd2,
        GNT_FILL = 2'd3
    } gnt_e;

endpackage

// File: rtl/dpr_fill.sv
// rtl/dpr_fill.sv - Memory-fill engine: latches a fill command and steps address/count on each grant
module dpr_fill #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   n,
    input  logic [7:0]    val,
    input  logic          gnt,
    output logic          req,
    output logic [AW-1:0] a,
    output logic [7:0]    d,
    output logic          busy
);

    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW-1:0] a_q, a_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [7:0]    d_q, d_d;
    logic          busy_q, busy_d;

    // A new command is only accepted while idle; a zero count never starts.
    always_comb begin
        a_d    = a_q;
        cnt_d  = cnt_q;
        d_d    = d_q;
        busy_d = busy_q;
        if (busy_q) begin
            if (gnt) begin
                a_d    = a_q + 1'b1;
                cnt_d  = cnt_q - 1'b1;
                busy_d = (cnt_q != CNT_ONE);
            end
        end else if (start && (n != '0)) begin
            a_d    = base;
            cnt_d  = n;
            d_d    = val;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            a_q    <= '0;
            cnt_q  <= '0;
            d_q    <= '0;
            busy_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            cnt_q  <= cnt_d;
            d_q    <= d_d;
            busy_q <= busy_d;
        end
    end

    assign req  = busy_q;
    assign a    = a_q;
    assign d    = d_q;
    assign busy = busy_q;

endmodule

// File: rtl/dpr_arb.sv
// rtl/dpr_arb.sv - Port-2 arbiter for the dual-port RAM: CPU first, loader/fill round-robin
module dpr_arb
    import dpr_arb_pkg::*;
#(
    parameter  int KB = 16,
    localparam int AW = $clog2(KB * 1024)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpuReq,
    input  logic          cpuWe,
    input  logic [AW-1:0] cpuA,
    input  logic [7:0]    cpuD,
    output logic [7:0]    cpuQ,
    output logic          cpuAck,
    input  logic          ldReq,
    input  logic [AW-1:0] ldA,
    input  logic [7:0]    ldD,
    output logic          ldAck,
    input  logic          fillStart,
    input  logic [AW-1:0] fillA,
    input  logic [AW:0]   fillN,
    input  logic [7:0]    fillD,
    output logic          fillBusy,
    output logic [AW-1:0] ramA,
    output logic [7:0]    ramD,
    output logic          ramW,
    input  logic [7:0]    ramQ
);

    gnt_e          gnt;
    logic          cpu_el, ld_el;
    logic          fill_req, fill_busy;
    logic [AW-1:0] fill_a;
    logic [7:0]    fill_d;

    logic          cpu_ack_q, cpu_ack_d;
    logic          rd_p1_q, rd_p1_d;
    logic [7:0]    cpu_q_q, cpu_q_d;
    logic          ld_ack_q, ld_ack_d;
    logic          rr_fill_q, rr_fill_d;
    logic [AW-1:0] ram_a_q, ram_a_d;
    logic [7:0]    ram_d_q, ram_d_d;

    dpr_fill #(.AW(AW)) u_fill (
        .clk    (clock),
        .resetn (reset),
        .start  (fillStart),
        .base   (fillA),
        .n      (fillN),
        .val    (fillD),
        .gnt    (gnt == GNT_FILL),
        .req    (fill_req),
        .a      (fill_a),
        .d      (fill_d),
        .busy   (fill_busy)
    );

    // A source is ineligible from its grant through its ack cycle; the pipeline flops mark that window.
    always_comb begin
        cpu_el = cpuReq & ~cpu_ack_q & ~rd_p1_q;
        ld_el  = ldReq & ~ld_ack_q;
        gnt    = GNT_NONE;
        if (reset) begin
            if (cpu_el)                gnt = GNT_CPU;
            else if (ld_el && fill_req) gnt = rr_fill_q ? GNT_FILL : GNT_LD;
            else if (ld_el)            gnt = GNT_LD;
            else if (fill_req)         gnt = GNT_FILL;
        end

        ramA = ram_a_q;
        ramD = ram_d_q;
        ramW = 1'b0;
        case (gnt)
            GNT_CPU:  begin ramA = cpuA;   ramD = cpuD;   ramW = cpuWe; end
            GNT_LD:   begin ramA = ldA;    ramD = ldD;    ramW = 1'b1;  end
            GNT_FILL: begin ramA = fill_a; ramD = fill_d; ramW = 1'b1;  end
            default:  ;
        endcase

        cpu_ack_d = ((gnt == GNT_CPU) && cpuWe) | rd_p1_q;
        rd_p1_d   = (gnt == GNT_CPU) && !cpuWe;
        cpu_q_d   = rd_p1_q ? ramQ : cpu_q_q;
        ld_ack_d  = (gnt == GNT_LD);
        rr_fill_d = ((gnt == GNT_LD) || (gnt == GNT_FILL)) ? ~rr_fill_q : rr_fill_q;
        ram_a_d   = ramA;
        ram_d_d   = ramD;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cpu_ack_q <= 1'b0;
            rd_p1_q   <= 1'b0;
            cpu_q_q   <= 8'h00;
            ld_ack_q  <= 1'b0;
            rr_fill_q <= 1'b0;
            ram_a_q   <= '0;
            ram_d_q   <= 8'h00;
        end else begin
            cpu_ack_q <= cpu_ack_d;
            rd_p1_q   <= rd_p1_d;
            cpu_q_q   <= cpu_q_d;
            ld_ack_q  <= ld_ack_d;
            rr_fill_q <= rr_fill_d;
            ram_a_q   <= ram_a_d;
            ram_d_q   <= ram_d_d;
        end
    end

    assign cpuQ     = cpu_q_q;
    assign cpuAck   = cpu_ack_q;
    assign ldAck    = ld_ack_q;
    assign fillBusy = fill_busy;

endmodule

// File: tb/tb_dpr_arb.sv
// tb/tb_dpr_arb.sv - Self-checking bench for dpr_arb with a cycle-level reference model
module tb_dpr_arb;

    localparam int AW = 14;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          cpuReq = 1'b0, cpuWe = 1'b0;
    logic [AW-1:0] cpuA = '0;
    logic [7:0]    cpuD = '0;
    logic [7:0]    cpuQ;
    logic          cpuAck;
    logic          ldReq = 1'b0;
    logic [AW-1:0] ldA = '0;
    logic [7:0]    ldD = '0;
    logic          ldAck;
    logic          fillStart = 1'b0;
    logic [AW-1:0] fillA = '0;
    logic [AW:0]   fillN = '0;
    logic [7:0]    fillD = '0;
    logic          fillBusy;
    logic [AW-1:0] ramA;
    logic [7:0]    ramD;
    logic          ramW;
    logic [7:0]    ramQ = '0;

    dpr_arb #(.KB(16)) dut (
        .clock(clock), .reset(reset),
        .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuA(cpuA), .cpuD(cpuD), .cpuQ(cpuQ), .cpuAck(cpuAck),
        .ldReq(ldReq), .ldA(ldA), .ldD(ldD), .ldAck(ldAck),
        .fillStart(fillStart), .fillA(fillA), .fillN(fillN), .fillD(fillD), .fillBusy(fillBusy),
        .ramA(ramA), .ramD(ramD), .ramW(ramW), .ramQ(ramQ)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write-first RAM behind port 2
    logic [7:0] env_mem [0:16383];
    always @(posedge clock) begin
        if (ramW) env_mem[ramA] <= ramD;
        ramQ <= ramW ? ramD : env_mem[ramA];
    end

    // Reference model: in-flight windows as absolute ack cycles, fill as address/remaining count
    logic [7:0]  mdl_mem [0:16383];
    int          cyc = 0;
    int          m_cpu_ack_at = -1, m_ld_ack_at = -1;
    bit          m_rd = 0, m_ld_first = 1, m_fbusy = 0;
    logic [7:0]  m_rd_val = '0, m_cpuq = '0, m_fval = '0, m_last_d = '0;
    logic [13:0] m_faddr = '0, m_last_a = '0;
    int          m_fleft = 0;

    always @(negedge clock) begin
        int          g;
        bit          cpu_el, ld_el, fb;
        logic        e_w;
        logic [13:0] e_a;
        logic [7:0]  e_d;
        if (!reset) begin
            chk("ramW_in_reset", ramW, 0);
            m_cpu_ack_at = -1; m_ld_ack_at = -1; m_rd = 0; m_cpuq = 8'h00;
            m_ld_first = 1; m_fbusy = 0; m_fleft = 0; m_last_a = '0; m_last_d = '0;
        end else begin
            cpu_el = cpuReq && (cyc > m_cpu_ack_at);
            ld_el  = ldReq && (cyc > m_ld_ack_at);
            fb     = m_fbusy;
            if (m_rd && cyc == m_cpu_ack_at) begin
                m_cpuq = m_rd_val;
                m_rd   = 0;
            end
            if (cpu_el)            g = 1;
            else if (ld_el && fb)  g = m_ld_first ? 2 : 3;
            else if (ld_el)        g = 2;
            else if (fb)           g = 3;
            else                   g = 0;
            e_w = 1'b0; e_a = m_last_a; e_d = m_last_d;
            if (g == 1) begin e_a = cpuA; e_d = cpuD; e_w = cpuWe; end
            if (g == 2) begin e_a = ldA;  e_d = ldD;  e_w = 1'b1; end
            if (g == 3) begin e_a = m_faddr; e_d = m_fval; e_w = 1'b1; end
            chk("ramW", ramW, e_w);
            chk("ramA", ramA, e_a);
            chk("ramD", ramD, e_d);
            chk("cpuAck", cpuAck, cyc == m_cpu_ack_at);
            chk("ldAck", ldAck, cyc == m_ld_ack_at);
            chk("fillBusy", fillBusy, fb);
            chk("cpuQ", cpuQ, m_cpuq);
            if (e_w) mdl_mem[e_a] = e_d;
            if (g != 0) begin m_last_a = e_a; m_last_d = e_d; end
            if (g == 1) begin
                m_cpu_ack_at = cyc + (cpuWe ? 1 : 2);
                m_rd = !cpuWe;
                m_rd_val = mdl_mem[cpuA];
            end
            if (g == 2) begin m_ld_ack_at = cyc + 1; m_ld_first = !m_ld_first; end
            if (g == 3) begin
                m_ld_first = !m_ld_first;
                m_faddr++;
                m_fleft--;
                if (m_fleft == 0) m_fbusy = 0;
            end
            if (fillStart && !fb && fillN != 0) begin
                m_fbusy = 1; m_faddr = fillA; m_fleft = int'(fillN); m_fval = fillD;
            end
        end
        cyc++;
    end

    // Random traffic, active only during the random phase
    bit rnd_mode = 0, rnd_new = 0;
    int cpu_pct = 20, ld_pct = 50;
    always @(posedge clock) begin
        #1;
        if (rnd_mode) begin
            if (cpuReq && cpuAck) cpuReq = 0;
            if (ldReq && ldAck) ldReq = 0;
            if (!cpuReq && rnd_new && $urandom_range(0, 99) < cpu_pct) begin
                cpuReq = 1; cpuWe = 1'($urandom_range(0, 1));
                cpuA = 14'($urandom_range(0, 63)); cpuD = 8'($urandom);
            end
            if (!ldReq && rnd_new && $urandom_range(0, 99) < ld_pct) begin
                ldReq = 1; ldA = 14'($urandom_range(0, 63)); ldD = 8'($urandom);
            end
            fillStart = rnd_new && ($urandom_range(0, 11) == 0);
            if (fillStart) begin
                fillA = $urandom_range(0, 3) == 0 ? 14'(16376 + $urandom_range(0, 7)) : 14'($urandom_range(0, 63));
                fillN = 15'($urandom_range(0, 12));
                fillD = 8'($urandom);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [13:0] wa [4];
    logic [13:0] fexp [4] = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
    int          busy_n, nw, bad;
    bit          got;
    logic [7:0]  q;

    initial begin
        for (int i = 0; i < 16384; i++) begin env_mem[i] = 8'h00; mdl_mem[i] = 8'h00; end
        repeat (3) @(posedge clock);
        #1 reset = 1;
        @(negedge clock);
        chk("rst_cpuAck", cpuAck, 0); chk("rst_ldAck", ldAck, 0);
        chk("rst_fillBusy", fillBusy, 0); chk("rst_cpuQ", cpuQ, 8'h00); chk("rst_ramA", ramA, 0);

        // CPU write then read of 14'h1234
        @(posedge clock); #1 cpuReq = 1; cpuWe = 1; cpuA = 14'h1234; cpuD = 8'h5A;
        @(negedge clock); chk("wr_grant_w", ramW, 1); chk("wr_grant_a", ramA, 14'h1234); chk("wr_grant_d", ramD, 8'h5A);
        @(posedge clock); #1 cpuReq = 0;
        @(negedge clock); chk("wr_ack", cpuAck, 1);
        @(posedge clock); #1 cpuReq = 1; cpuWe = 0;
        @(negedge clock); chk("rd_grant_w", ramW, 0); chk("rd_grant_a", ramA, 14'h1234);
        @(posedge clock); #1 cpuReq = 0;
        @(negedge clock); chk("rd_ack_early", cpuAck, 0);
        @(posedge clock); #1;
        @(negedge clock); chk("rd_ack", cpuAck, 1); chk("rd_data", cpuQ, 8'h5A);

        // Wrapping fill of 4 bytes
        @(posedge clock); #1 fillStart = 1; fillA = 14'h3FFE; fillN = 15'd4; fillD = 8'hAA;
        @(negedge clock); chk("fill_idle_at_start", fillBusy, 0);
        busy_n = 0; nw = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clock); #1 fillStart = 0; fillN = '0;
            @(negedge clock);
            if (fillBusy) busy_n++;
            if (ramW) begin
                if (nw < 4) wa[nw] = ramA;
                nw++;
            end
        end
        chk("fill_busy_cycles", busy_n, 4);
        chk("fill_writes", nw, 4);
        for (int k = 0; k < 4; k++) chk("fill_addr", wa[k], fexp[k]);

        // fillStart while busy, then fillN=0 while idle
        @(posedge clock); #1 fillStart = 1; fillA = 14'h0100; fillN = 15'd3; fillD = 8'h11;
        @(posedge clock); #1 fillStart = 1; fillA = 14'h0200; fillN = 15'd8; fillD = 8'h22;
        busy_n = 0; nw = 0;
        @(negedge clock); if (fillBusy) busy_n++;
        for (int k = 0; k < 8; k++) begin
            @(posedge clock); #1 fillStart = 0;
            @(negedge clock);
            if (fillBusy) busy_n++;
            if (ramW && ramA[13:8] == 6'h02) nw++;
        end
        chk("busy_start_ignored_cycles", busy_n, 3);
        chk("busy_start_ignored_writes", nw, 0);
        @(posedge clock); #1 fillStart = 1; fillA = 14'h0300; fillN = '0;
        busy_n = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock); if (fillBusy || ramW) busy_n++;
            @(posedge clock); #1 fillStart = 0;
        end
        chk("zero_fill_ignored", busy_n, 0);

        // Reset in the cycle after a CPU read grant
        @(posedge clock); #1 cpuReq = 1; cpuWe = 0; cpuA = 14'h1234;
        @(negedge clock); chk("rst_rd_grant_a", ramA, 14'h1234);
        @(posedge clock); #1 cpuReq = 0; reset = 0;
        @(negedge clock); chk("rst_rd_ramW", ramW, 0);
        @(posedge clock); #1 reset = 1;
        @(negedge clock); chk("rst_rd_no_ack", cpuAck, 0); chk("rst_rd_cpuQ", cpuQ, 8'h00);
        @(posedge clock); #1 cpuReq = 1;
        got = 0; q = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (cpuAck) begin got = 1; q = cpuQ; break; end
        end
        @(posedge clock); #1 cpuReq = 0;
        chk("rerd_ack", got, 1); chk("rerd_data", q, 8'h5A);

        // Loader and fill contending, no CPU: LD, FILL, LD, ...
        @(posedge clock); #1 fillStart = 1; fillA = 14'h1000; fillN = 15'd8; fillD = 8'h33;
        @(posedge clock); #1 fillStart = 0; ldReq = 1; ldA = 14'h2000; ldD = 8'h44;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk("alt_w", ramW, 1);
            chk("alt_src", ramA[13:12], (k % 2 == 0) ? 2 : 1);
            chk("alt_ldAck", ldAck, k % 2);
            @(posedge clock); #1;
        end
        ldReq = 0;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (!fillBusy && !ldAck) begin got = 1; break; end
        end
        chk("alt_fill_done", got, 1);

        // Random phases: mixed, CPU saturating, no CPU
        @(posedge clock);
        rnd_mode = 1; rnd_new = 1;
        cpu_pct = 20; ld_pct = 50; repeat (1500) @(posedge clock);
        cpu_pct = 100; repeat (300) @(posedge clock);
        cpu_pct = 0; ld_pct = 70; repeat (1000) @(posedge clock);
        cpu_pct = 30; ld_pct = 30; repeat (1000) @(posedge clock);
        rnd_new = 0;
        got = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (!cpuReq && !ldReq && !fillBusy) begin got = 1; break; end
        end
        chk("drain", got, 1);
        @(posedge clock); #1 rnd_mode = 0; fillStart = 0;
        repeat (3) @(posedge clock);

        bad = 0;
        for (int i = 0; i < 16384; i++) if (env_mem[i] !== mdl_mem[i]) bad++;
        chk("mem_final", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dpr_arb.md
# dpr_arb

Single-port access arbiter and fill sequencer for the write-capable port (port 2) of the core's 8-bit dual-port RAMs. Shares that port between the CPU, a bulk loader (ROM/tape image writer) and an internal memory-fill engine, one access per clock. Port 1 (video/read side) is untouched. Sits between the CPU bus decode and a `dprf`-style RAM instance.

## Interface
- `KB`, 16: RAM size in KB.
- `AW`, $clog2(KB*1024): address width, derived, not overridden.

- `clock` in 1: single clock, RAM port-2 clock.
- `reset` in 1: synchronous, active-low.
- `cpuReq` in 1: CPU access request, held until `cpuAck`.
- `cpuWe` in 1: 1 = write, 0 = read.
- `cpuA` in AW: CPU address.
- `cpuD` in 8: CPU write data.
- `cpuQ` out 8: CPU read data, registered.
- `cpuAck` out 1: one-cycle completion pulse.
- `ldReq` in 1: loader write request, held until `ldAck`.
- `ldA` in AW: loader address.
- `ldD` in 8: loader data.
- `ldAck` out 1: one-cycle completion pulse.
- `fillStart` in 1: one-cycle fill command.
- `fillA` in AW: fill base address.
- `fillN` in AW+1: byte count; 0 = no-op.
- `fillD` in 8: fill value.
- `fillBusy` out 1: fill in progress.
- `ramA` out AW, `ramD` out 8, `ramW` out 1: to RAM `a2`/`d2`/`w2`.
- `ramQ` in 8: from RAM `q2` (1-cycle registered read).

## Operation
- Each cycle grants the RAM port to at most one eligible source; `ramA`/`ramD`/`ramW` are combinational from the grant; no grant: `ramW`=0, `ramA`/`ramD` hold last granted values.
- Priority: CPU fixed highest; loader vs fill round-robin on the cycles the CPU does not take. Pointer toggles only when one of the two is granted; after reset loader wins the first tie.
- Eligibility: source requesting and no transaction of its own in flight. A source is in flight from grant cycle through its ack cycle inclusive; `req` still high in the ack cycle is a new request, eligible the following cycle.
- CPU write: grant cycle N writes `cpuD` to `cpuA`; `cpuAck` in N+1.
- CPU read: grant N drives `cpuA`; `ramQ` valid N+1, captured into `cpuQ` end of N+1; `cpuAck` in N+2 with `cpuQ` valid; `cpuQ` holds until next read completes.
- Loader: write-only; as CPU write, `ldAck` in N+1.
- Fill: `fillStart` while idle and `fillN`≠0 latches base/count/value; `fillBusy` high from next cycle. Each fill grant writes value at current address, address += 1 mod 2^AW (wraps), count −= 1. `fillBusy` drops the cycle after the last write. `fillStart` while busy or with `fillN`=0 ignored.
- Reset (low at a clock edge, also mid-transaction): `cpuAck`=0, `ldAck`=0, `fillBusy`=0, `cpuQ`=8'h00, RR pointer = loader, in-flight flags cleared, held `ramA`=0, `ramD`=0; `ramW` forced 0 while `reset` low. Pending transactions are dropped, no ack; requesters re-request.

## Timing
- Throughput: CPU write 1 per 2 cycles, read 1 per 3; loader 1 per 2; fill 1 per cycle when uncontended.
- CPU saturating the port starves loader/fill indefinitely (by design; Z80 bus cannot saturate).
- Loader and fill both continuously requesting, no CPU: fill, loader alternate; fill rate halves.
- Fill of N bytes uncontended: `fillBusy` high exactly N cycles.
- Read-after-write same address from different sources in consecutive grants returns new data (RAM is write-first on port 2).

## Structure
- Shared include: grant encoding constants `GNT_NONE`, `GNT_CPU`, `GNT_LD`, `GNT_FILL`.
- Sub-module `dpr_fill`: latches command, holds address/count, exposes `req`, `a`, `d`, `busy`, advances on `gnt`. Arbiter and ack pipelines stay in `dpr_arb`.

## Test plan
- CPU write 8'h5A to 14'h1234 then read 14'h1234 → `cpuAck` one cycle after write grant, read `cpuAck` two cycles after grant with `cpuQ`=8'h5A.
- Fill base 14'h3FFE, N=4, value 8'hAA, idle → writes 3FFE, 3FFF, 0000, 0001; `fillBusy` high exactly 4 cycles.
- Loader and fill both active, no CPU → grants alternate LD, FILL, LD…; loader first after reset; each `ldAck` one cycle after its grant.
- CPU request asserted every cycle during a fill → CPU granted on every eligible cycle, fill advances only on CPU in-flight cycles; final memory correct.
- `fillStart` while busy, and `fillN`=0 → ignored, no writes, `fillBusy` unchanged.
- `reset` low mid CPU read (grant cycle +1) → no `cpuAck`, `cpuQ`=8'h00, `ramW`=0 during reset; fresh request after release completes normally.
